// File: rtl/sobel_edge_pkg.sv
// Shared constants, state type and helpers for the Sobel edge detector.
package sobel_edge_pkg;

  localparam int unsigned PixW   = 8;
  localparam int unsigned MagW   = 11;
  localparam int unsigned CoordW = 8;

  typedef enum logic {StIdle, StRun} sobel_state_e;

  // Magnitude of a two's-complement gradient; inputs never reach -1024.
  function automatic logic [MagW-1:0] abs_grad(input logic [MagW-1:0] g);
    return g[MagW-1] ? (~g + 1'b1) : g;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: one write and one registered read per cycle.
module sobel_line_buffer
  import sobel_edge_pkg::*;
#(
  parameter int unsigned COLS = 10,
  localparam int unsigned AW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            Clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [PixW-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [PixW-1:0] rdata_o
);

  logic [PixW-1:0] mem_q [COLS];
  logic [PixW-1:0] rdata_q;

  // Read returns the value stored before this cycle's write.
  always_ff @(posedge Clk) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge detector with raster-order pixel input.
module sobel_edge
  import sobel_edge_pkg::*;
#(
  parameter int unsigned COLS   = 10,
  parameter int unsigned ROWS   = 10,
  parameter int unsigned THRESH = 100
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic [PixW-1:0]   Pixel,
  input  logic              Frame,
  input  logic              Line,
  output logic              EdgeValid,
  output logic              Edge,
  output logic [MagW-1:0]   Mag,
  output logic [CoordW-1:0] EdgeX,
  output logic [CoordW-1:0] EdgeY,
  output logic              FrameDone
);

  localparam int unsigned AW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CoordW:0]   ColsLim = (CoordW+1)'(COLS);
  localparam logic [CoordW:0]   RowsLim = (CoordW+1)'(ROWS);
  localparam logic [CoordW-1:0] LastX   = CoordW'(COLS - 2);
  localparam logic [CoordW-1:0] LastY   = CoordW'(ROWS - 2);
  localparam logic [MagW-1:0]   Thresh  = MagW'(THRESH);

  sobel_state_e      state_q, state_d;
  logic [CoordW-1:0] col_q, col_d, row_q, row_d;
  logic              accept;
  logic              act_q, win_valid_q, win_valid_d;
  logic [CoordW-1:0] cx_q, cy_q;
  logic [PixW-1:0]   pix_q, rd1, rd2;
  logic              wb_en;

  // Columns of the 3x3 window; element 0 is the top row.
  logic [2:0][PixW-1:0] colm2_q, colm1_q, right_col;

  logic [MagW-1:0]   gx_pos, gx_neg, gy_pos, gy_neg, gx_d, gy_d, gx_q, gy_q;
  logic              s2_valid_q;
  logic [CoordW-1:0] s2_x_q, s2_y_q;
  logic [MagW-1:0]   mag_d;

  assign accept = Frame || (state_q == StRun);

  // Next state and position of the pixel presented this cycle.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: if (Frame) state_d = StRun;
      StRun:  state_d = StRun;
    endcase
    if (Frame) begin
      col_d = '0;
      row_d = '0;
    end else if (state_q == StRun) begin
      if (Line) begin
        col_d = '0;
        if (row_q != '1) row_d = row_q + 1'b1;
      end else if (col_q != '1) begin
        col_d = col_q + 1'b1;
      end
    end
    win_valid_d = accept && (col_d >= CoordW'(2)) && (row_d >= CoordW'(2)) &&
                  ({1'b0, col_d} < ColsLim) && ({1'b0, row_d} < RowsLim);
  end

  // State, counters and the window-stage pixel register.
  always_ff @(posedge Clk) begin
    if (nReset) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      act_q       <= 1'b0;
      win_valid_q <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      act_q       <= accept;
      win_valid_q <= win_valid_d;
      cx_q        <= col_d - CoordW'(1);
      cy_q        <= row_d - CoordW'(1);
      pix_q       <= Pixel;
    end
  end

  // Write-back happens one cycle after the read of the same column.
  assign wb_en = act_q && ({1'b0, col_q} < ColsLim);

  sobel_line_buffer #(.COLS(COLS)) u_lb_row1 (
    .Clk     (Clk),
    .we_i    (wb_en),
    .waddr_i (col_q[AW-1:0]),
    .wdata_i (pix_q),
    .raddr_i (col_d[AW-1:0]),
    .rdata_o (rd1)
  );

  sobel_line_buffer #(.COLS(COLS)) u_lb_row2 (
    .Clk     (Clk),
    .we_i    (wb_en),
    .waddr_i (col_q[AW-1:0]),
    .wdata_i (rd1),
    .raddr_i (col_d[AW-1:0]),
    .rdata_o (rd2)
  );

  assign right_col = {pix_q, rd1, rd2};

  // Shift the window left by one column every cycle.
  always_ff @(posedge Clk) begin
    colm2_q <= colm1_q;
    colm1_q <= right_col;
  end

  // Horizontal and vertical gradients as 11-bit two's complement.
  always_comb begin
    gx_pos = MagW'(right_col[0]) + (MagW'(right_col[1]) << 1) + MagW'(right_col[2]);
    gx_neg = MagW'(colm2_q[0]) + (MagW'(colm2_q[1]) << 1) + MagW'(colm2_q[2]);
    gy_pos = MagW'(colm2_q[2]) + (MagW'(colm1_q[2]) << 1) + MagW'(right_col[2]);
    gy_neg = MagW'(colm2_q[0]) + (MagW'(colm1_q[0]) << 1) + MagW'(right_col[0]);
    gx_d   = gx_pos - gx_neg;
    gy_d   = gy_pos - gy_neg;
    mag_d  = abs_grad(gx_q) + abs_grad(gy_q);
  end

  // Gradient register stage.
  always_ff @(posedge Clk) begin
    if (nReset) begin
      s2_valid_q <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
    end else begin
      s2_valid_q <= win_valid_q;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      s2_x_q     <= cx_q;
      s2_y_q     <= cy_q;
    end
  end

  // Magnitude/compare output stage; data outputs hold between results.
  always_ff @(posedge Clk) begin
    if (nReset) begin
      EdgeValid <= 1'b0;
      Edge      <= 1'b0;
      Mag       <= '0;
      EdgeX     <= '0;
      EdgeY     <= '0;
      FrameDone <= 1'b0;
    end else begin
      EdgeValid <= s2_valid_q;
      Edge      <= s2_valid_q && (mag_d >= Thresh);
      if (s2_valid_q) begin
        Mag   <= mag_d;
        EdgeX <= s2_x_q;
        EdgeY <= s2_y_q;
      end
      FrameDone <= EdgeValid && (EdgeX == LastX) && (EdgeY == LastY);
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Self-checking bench for sobel_edge against a window-arithmetic reference model.
module tb_sobel_edge;

  localparam int COLS = 10;
  localparam int ROWS = 10;

  logic        Clk = 1'b0;
  logic        nReset = 1'b1;
  logic [7:0]  Pixel = '0;
  logic        Frame = 1'b0;
  logic        Line = 1'b0;
  logic        EdgeValid, Edge, FrameDone;
  logic [10:0] Mag;
  logic [7:0]  EdgeX, EdgeY;
  logic        ev_a, e_a, fd_a, ev_b, e_b, fd_b;
  logic [10:0] mag_a, mag_b;
  logic [7:0]  x_a, y_a, x_b, y_b;

  sobel_edge #(.COLS(COLS), .ROWS(ROWS), .THRESH(100)) dut (
    .Clk(Clk), .nReset(nReset), .Pixel(Pixel), .Frame(Frame), .Line(Line),
    .EdgeValid(EdgeValid), .Edge(Edge), .Mag(Mag), .EdgeX(EdgeX), .EdgeY(EdgeY),
    .FrameDone(FrameDone)
  );

  sobel_edge #(.COLS(COLS), .ROWS(ROWS), .THRESH(800)) dut_t800 (
    .Clk(Clk), .nReset(nReset), .Pixel(Pixel), .Frame(Frame), .Line(Line),
    .EdgeValid(ev_a), .Edge(e_a), .Mag(mag_a), .EdgeX(x_a), .EdgeY(y_a),
    .FrameDone(fd_a)
  );

  sobel_edge #(.COLS(COLS), .ROWS(ROWS), .THRESH(801)) dut_t801 (
    .Clk(Clk), .nReset(nReset), .Pixel(Pixel), .Frame(Frame), .Line(Line),
    .EdgeValid(ev_b), .Edge(e_b), .Mag(mag_b), .EdgeX(x_b), .EdgeY(y_b),
    .FrameDone(fd_b)
  );

  typedef struct packed {
    int cyc; int x; int y; int mag; bit edg; bit e800; bit e801;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   bad_edge = 0;
  int   img [ROWS][COLS];
  int   pix_cyc [ROWS][COLS];
  int   kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int   ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
  res_t obs_q[$];
  res_t exp_q[$];
  int   done_q[$];
  res_t mon_r;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Record every result and FrameDone pulse, sampled mid-cycle.
  always @(negedge Clk) begin
    if (EdgeValid === 1'b1) begin
      mon_r.cyc  = cyc;
      mon_r.x    = int'(EdgeX);
      mon_r.y    = int'(EdgeY);
      mon_r.mag  = int'(Mag);
      mon_r.edg  = Edge;
      mon_r.e800 = e_a;
      mon_r.e801 = e_b;
      obs_q.push_back(mon_r);
    end
    if (FrameDone === 1'b1) done_q.push_back(cyc);
    if (EdgeValid === 1'b0 && Edge !== 1'b0) bad_edge++;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      Pixel = 8'($urandom);
      Frame = 1'b0;
      Line  = 1'b0;
      tick();
    end
  endtask

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic drive_rows(input int nrows);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < COLS; c++) begin
        Pixel = 8'(img[r][c]);
        Frame = (r == 0 && c == 0);
        Line  = (c == 0);
        pix_cyc[r][c] = cyc;
        tick();
      end
    end
    Frame = 1'b0;
    Line  = 1'b0;
  endtask

  // Reference: convolve every interior centre whose bottom row was delivered.
  task automatic build_expected(input int nrows);
    for (int y = 1; y <= ROWS - 2 && y + 1 < nrows; y++) begin
      for (int x = 1; x <= COLS - 2; x++) begin
        int gx, gy, m;
        res_t e;
        gx = 0;
        gy = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            gx += img[y - 1 + r][x - 1 + c] * kx[r][c];
            gy += img[y - 1 + r][x - 1 + c] * ky[r][c];
          end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e.cyc  = pix_cyc[y + 1][x + 1] + 3;
        e.x    = x;
        e.y    = y;
        e.mag  = m;
        e.edg  = (m >= 100);
        e.e800 = (m >= 800);
        e.e801 = (m >= 801);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    nReset = 1'b1;
    Frame  = 1'b1;
    Line   = 1'b1;
    Pixel  = 8'($urandom);
    repeat (4) tick();
    @(negedge Clk);
    checks++; if (EdgeValid !== 1'b0) begin errors++; $display("FAIL reset_ev: got %b want 0", EdgeValid); end
    checks++; if (Edge !== 1'b0) begin errors++; $display("FAIL reset_edge: got %b want 0", Edge); end
    checks++; if (FrameDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", FrameDone); end
    checks++; if (Mag !== 11'd0) begin errors++; $display("FAIL reset_mag: got %0d want 0", Mag); end
    checks++; if (EdgeX !== 8'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", EdgeX); end
    checks++; if (EdgeY !== 8'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", EdgeY); end
    nReset = 1'b0;
    Frame  = 1'b0;
    Line   = 1'b0;
    clear_logs();
    tick();
    for (int i = 0; i < 30; i++) begin
      Pixel = 8'($urandom);
      Line  = ($urandom_range(0, 3) == 0);
      tick();
    end
    Line = 1'b0;
    checks++;
    if (obs_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d results %0d done want 0 0", obs_q.size(), done_q.size());
    end
  endtask

  task automatic test_flat();
    clear_logs();
    foreach (img[r, c]) img[r][c] = 128;
    drive_rows(ROWS);
    idle(8);
    build_expected(ROWS);
    checks++;
    if (obs_q.size() != 64) begin errors++; $display("FAIL flat_count: got %0d want 64", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].mag != 0 || obs_q[i].edg) begin
        errors++;
        $display("FAIL flat_res[%0d]: got cyc=%0d x=%0d y=%0d mag=%0d e=%0d want cyc=%0d x=%0d y=%0d mag=0 e=0",
                 i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].mag, obs_q[i].edg,
                 exp_q[i].cyc, exp_q[i].x, exp_q[i].y);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != exp_q[exp_q.size() - 1].cyc + 1) begin
      errors++;
      $display("FAIL flat_done: got %0d pulses want 1 at cyc %0d", done_q.size(),
               exp_q[exp_q.size() - 1].cyc + 1);
    end
  endtask

  task automatic test_step();
    int want;
    clear_logs();
    foreach (img[r, c]) img[r][c] = (c >= 5) ? 200 : 0;
    drive_rows(ROWS);
    idle(8);
    build_expected(ROWS);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL step_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      want = (obs_q[i].x == 4 || obs_q[i].x == 5) ? 800 : 0;
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].mag != want || obs_q[i].edg != (want != 0)) begin
        errors++;
        $display("FAIL step_res[%0d]: got x=%0d y=%0d mag=%0d e=%0d e800=%0d want mag=%0d e=%0d",
                 i, obs_q[i].x, obs_q[i].y, obs_q[i].mag, obs_q[i].edg, obs_q[i].e800,
                 want, want != 0);
      end
      if (want == 800) begin
        checks++;
        if (obs_q[i].e800 !== 1'b1 || obs_q[i].e801 !== 1'b0) begin
          errors++;
          $display("FAIL step_thresh x=%0d y=%0d: got t800=%0d t801=%0d want 1 0",
                   obs_q[i].x, obs_q[i].y, obs_q[i].e800, obs_q[i].e801);
        end
      end
    end
  endtask

  task automatic test_impulse();
    int found;
    clear_logs();
    foreach (img[r, c]) img[r][c] = 0;
    img[5][5] = 255;
    drive_rows(ROWS);
    idle(8);
    build_expected(ROWS);
    found = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if ((obs_q[i].x == 5 && obs_q[i].y == 5) || (obs_q[i].x == 4 && obs_q[i].y == 5) ||
          (obs_q[i].x == 4 && obs_q[i].y == 4)) begin
        found++;
        checks++;
        if (obs_q[i].mag != ((obs_q[i].x == 5) ? 0 : 510)) begin
          errors++;
          $display("FAIL impulse_spot (%0d,%0d): got mag=%0d want %0d", obs_q[i].x,
                   obs_q[i].y, obs_q[i].mag, (obs_q[i].x == 5) ? 0 : 510);
        end
      end
    end
    checks++;
    if (found != 3) begin errors++; $display("FAIL impulse_found: got %0d want 3", found); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL impulse_res[%0d]: got x=%0d y=%0d mag=%0d want x=%0d y=%0d mag=%0d",
                 i, obs_q[i].x, obs_q[i].y, obs_q[i].mag, exp_q[i].x, exp_q[i].y, exp_q[i].mag);
      end
    end
  endtask

  task automatic test_random();
    res_t last;
    clear_logs();
    foreach (img[r, c]) img[r][c] = int'($urandom_range(0, 255));
    drive_rows(ROWS);
    idle(8);
    build_expected(ROWS);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_res[%0d]: got cyc=%0d x=%0d y=%0d mag=%0d e=%0d want cyc=%0d x=%0d y=%0d mag=%0d e=%0d",
                 i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].mag, obs_q[i].edg,
                 exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].mag, exp_q[i].edg);
      end
    end
    last = exp_q[exp_q.size() - 1];
    @(negedge Clk);
    checks++;
    if (Mag !== 11'(last.mag) || EdgeX !== 8'(last.x) || EdgeY !== 8'(last.y) || Edge !== 1'b0) begin
      errors++;
      $display("FAIL rand_hold: got mag=%0d x=%0d y=%0d e=%b want mag=%0d x=%0d y=%0d e=0",
               Mag, EdgeX, EdgeY, Edge, last.mag, last.x, last.y);
    end
    checks++;
    if (bad_edge != 0) begin errors++; $display("FAIL edge_unqualified: got %0d want 0", bad_edge); end
    tick();
  endtask

  task automatic test_reset_mid();
    int r_cyc, early;
    clear_logs();
    foreach (img[r, c]) img[r][c] = int'($urandom_range(0, 255));
    drive_rows(5);
    for (int c = 0; c < 3; c++) begin
      Pixel = 8'(img[5][c]);
      Line  = (c == 0);
      tick();
    end
    Line   = 1'b0;
    Pixel  = 8'(img[5][3]);
    nReset = 1'b1;
    r_cyc  = cyc;
    tick();
    nReset = 1'b0;
    idle(3);
    early = 0;
    foreach (obs_q[i]) if (obs_q[i].cyc > r_cyc) early++;
    checks++;
    if (early != 0) begin errors++; $display("FAIL rst_quiet: got %0d results want 0", early); end
    clear_logs();
    foreach (img[r, c]) img[r][c] = int'($urandom_range(0, 255));
    drive_rows(ROWS);
    idle(8);
    checks++;
    if (obs_q.size() != 64) begin errors++; $display("FAIL rst_count: got %0d want 64", obs_q.size()); end
    checks++;
    if (obs_q.size() == 0 || obs_q[0].cyc != pix_cyc[2][2] + 3 || obs_q[0].x != 1 || obs_q[0].y != 1) begin
      errors++;
      $display("FAIL rst_first: got %0d results first cyc=%0d x=%0d y=%0d want cyc=%0d x=1 y=1",
               obs_q.size(), (obs_q.size() != 0) ? obs_q[0].cyc : -1,
               (obs_q.size() != 0) ? obs_q[0].x : -1, (obs_q.size() != 0) ? obs_q[0].y : -1,
               pix_cyc[2][2] + 3);
    end
    checks++;
    if (done_q.size() != 1) begin errors++; $display("FAIL rst_done: got %0d want 1", done_q.size()); end
  endtask

  task automatic test_restart();
    clear_logs();
    foreach (img[r, c]) img[r][c] = int'($urandom_range(0, 255));
    drive_rows(6);
    build_expected(6);
    foreach (img[r, c]) img[r][c] = int'($urandom_range(0, 255));
    drive_rows(ROWS);
    idle(8);
    build_expected(ROWS);
    checks++;
    if (obs_q.size() != 96) begin
      errors++; $display("FAIL restart_count: got %0d want 96 (32 old + 64 new)", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL restart_res[%0d]: got cyc=%0d x=%0d y=%0d mag=%0d want cyc=%0d x=%0d y=%0d mag=%0d",
                 i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].mag,
                 exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].mag);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != exp_q[exp_q.size() - 1].cyc + 1) begin
      errors++;
      $display("FAIL restart_done: got %0d pulses want 1 at cyc %0d", done_q.size(),
               exp_q[exp_q.size() - 1].cyc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_impulse();
    test_random();
    test_reset_mid();
    test_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
